// File: rtl/entity_table.sv
// Writable entity store: direct writes, grid-fill sequencer, clear; registered 1-cycle read.
// Entries at or beyond entities_number read as zero; cmd_clear > cmd_fill > wr_en when they coincide.
module entity_table #(
  parameter int TYPE_W    = 3,
  parameter int COORD_W   = 9,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 128,
  parameter int GRID_ROWS = 10,
  parameter int GRID_COLS = 10,
  parameter int STEP      = 48,
  parameter int FILL_TYPE = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           address_read_ent,
  output logic [TYPE_W+2*COORD_W-1:0] data_read_ent,
  output logic [ADDR_W-1:0]           entities_number,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [TYPE_W+2*COORD_W-1:0] wr_data,
  output logic                        wr_err,
  input  logic                        cmd_fill,
  input  logic                        cmd_clear,
  output logic                        busy,
  output logic                        done
);

  localparam int REC_W  = TYPE_W + 2*COORD_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_N = (GRID_ROWS*GRID_COLS < DEPTH) ? GRID_ROWS*GRID_COLS : DEPTH;
  localparam int CCOL_W = $clog2(GRID_COLS + 1);

  localparam logic [ADDR_W:0]      DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]      FILL_LAST = (ADDR_W+1)'(FILL_N - 1);
  localparam logic [CCOL_W-1:0]    COL_LAST  = CCOL_W'(GRID_COLS - 1);
  localparam logic [COORD_W-1:0]   STEP_C    = COORD_W'(STEP);
  localparam logic [TYPE_W-1:0]    FILL_T    = TYPE_W'(FILL_TYPE);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]         state;
  logic [ADDR_W:0]    cnt;
  logic [CCOL_W-1:0]  col_cnt;
  logic [COORD_W-1:0] row_acc;
  logic [COORD_W-1:0] col_acc;
  logic [REC_W-1:0]   rd_dat;
  logic               wr_err_q;
  logic               done_q;

  logic [REC_W-1:0]   mem [DEPTH];

  logic               wr_in_range;
  logic               wr_append;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [REC_W-1:0]   mem_wdat;
  logic               rd_valid;

  // Count is one bit wider than the address so a completely full table is representable.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < cnt);
    wr_append   = ({1'b0, wr_addr} == cnt) && (cnt < DEPTH_C);
    rd_valid    = ({1'b0, address_read_ent} < cnt);
    mem_we      = 1'b0;
    mem_widx    = cnt[IDX_W-1:0];
    mem_wdat    = {FILL_T, row_acc, col_acc};
    if (!cmd_clear) begin
      if (state == FILL) begin
        mem_we = 1'b1;
      end else if (!cmd_fill && wr_en && (wr_in_range || wr_append)) begin
        mem_we   = 1'b1;
        mem_widx = wr_addr[IDX_W-1:0];
        mem_wdat = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      col_cnt  <= '0;
      row_acc  <= '0;
      col_acc  <= '0;
      rd_dat   <= '0;
      wr_err_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_err_q <= 1'b0;
      done_q   <= 1'b0;
      rd_dat   <= rd_valid ? mem[address_read_ent[IDX_W-1:0]] : '0;
      if (cmd_clear) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == FILL) begin
        cnt <= cnt + 1'b1;
        // Accumulators step by STEP and wrap at COORD_W bits instead of multiplying row/col.
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          col_acc <= '0;
          row_acc <= row_acc + STEP_C;
        end else begin
          col_cnt <= col_cnt + 1'b1;
          col_acc <= col_acc + STEP_C;
        end
        if (cnt == FILL_LAST) begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
      end else if (cmd_fill) begin
        state   <= FILL;
        cnt     <= '0;
        col_cnt <= '0;
        row_acc <= '0;
        col_acc <= '0;
      end else if (wr_en) begin
        if (wr_append)         cnt      <= cnt + 1'b1;
        else if (!wr_in_range) wr_err_q <= 1'b1;
      end
    end
  end

  assign data_read_ent   = rd_dat;
  assign entities_number = cnt[ADDR_W-1:0];
  assign wr_err          = wr_err_q;
  assign busy            = (state == FILL);
  assign done            = done_q;

endmodule

// File: tb/tb_entity_table.sv
// Randomized and directed bench for entity_table against a per-cycle table model.
module tb_entity_table;

  localparam int DEPTH = 128;
  localparam int NFILL = 100;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rd_addr;
  logic [20:0] rd_data;
  logic [7:0]  ent_num;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [20:0] wr_data;
  logic        wr_err;
  logic        cmd_fill;
  logic        cmd_clear;
  logic        busy;
  logic        done;

  logic [7:0]  d12_rd_addr;
  logic [20:0] d12_rd_data;
  logic [7:0]  d12_cnt;
  logic        d12_wr_en;
  logic [7:0]  d12_wr_addr;
  logic [20:0] d12_wr_data;
  logic        d12_err;
  logic        d12_fill;
  logic        d12_clear;
  logic        d12_busy;
  logic        d12_done;

  entity_table dut (
    .clk(clk), .rst_n(rst_n),
    .address_read_ent(rd_addr), .data_read_ent(rd_data), .entities_number(ent_num),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .cmd_fill(cmd_fill), .cmd_clear(cmd_clear), .busy(busy), .done(done)
  );

  entity_table #(.GRID_ROWS(12), .GRID_COLS(12)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .address_read_ent(d12_rd_addr), .data_read_ent(d12_rd_data), .entities_number(d12_cnt),
    .wr_en(d12_wr_en), .wr_addr(d12_wr_addr), .wr_data(d12_wr_data), .wr_err(d12_err),
    .cmd_fill(d12_fill), .cmd_clear(d12_clear), .busy(d12_busy), .done(d12_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference table: contents, valid count and whether a fill is running.
  logic [20:0] m_mem [256];
  int          m_cnt  = 0;
  bit          m_busy = 0;
  int          busy_cycles = 0;
  int          done_cnt    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] rec(input int t, input int r, input int c);
    logic [2:0] tt;
    logic [8:0] rr;
    logic [8:0] cc;
    tt = 3'(t);
    rr = 9'(r % 512);
    cc = 9'(c % 512);
    return {tt, rr, cc};
  endfunction

  function automatic logic [20:0] fill_rec(input int i, input int cols);
    return rec(4, (i / cols) * 48, (i % cols) * 48);
  endfunction

  task automatic idle_inputs();
    wr_en = 0; cmd_fill = 0; cmd_clear = 0;
  endtask

  // One clock of the main DUT: predict from current inputs, step, then compare.
  task automatic cycle();
    logic [20:0] e_rd;
    bit          e_err;
    bit          e_done;
    e_rd   = (int'(rd_addr) < m_cnt) ? m_mem[rd_addr] : 21'd0;
    e_err  = 0;
    e_done = 0;
    if (cmd_clear) begin
      m_cnt = 0; m_busy = 0;
    end else if (m_busy) begin
      m_mem[m_cnt] = fill_rec(m_cnt, 10);
      m_cnt++;
      if (m_cnt == NFILL) begin m_busy = 0; e_done = 1; end
    end else if (cmd_fill) begin
      m_busy = 1; m_cnt = 0;
    end else if (wr_en) begin
      if (int'(wr_addr) < m_cnt) m_mem[wr_addr] = wr_data;
      else if (int'(wr_addr) == m_cnt && m_cnt < DEPTH) begin
        m_mem[wr_addr] = wr_data; m_cnt++;
      end else e_err = 1;
    end
    @(posedge clk);
    #1;
    check("rd_data", 32'(rd_data), 32'(e_rd));
    check("count", 32'(ent_num), 32'(m_cnt));
    check("wr_err", 32'(wr_err), 32'(e_err));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(e_done));
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [20:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    cycle();
    idle_inputs();
  endtask

  task automatic read_expect(input string tag, input logic [7:0] a, input logic [20:0] exp);
    rd_addr = a;
    cycle();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    bit seen;
    rst_n = 0; rd_addr = 0; wr_addr = 0; wr_data = 0;
    idle_inputs();
    d12_rd_addr = 0; d12_wr_en = 0; d12_wr_addr = 0; d12_wr_data = 0;
    d12_fill = 0; d12_clear = 0;
    repeat (2) @(negedge clk);
    check("rst_data", 32'(rd_data), 0);
    check("rst_count", 32'(ent_num), 0);
    check("rst_err", 32'(wr_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1;
    @(negedge clk);

    // Default grid fill: 100 entries, busy for exactly 100 cycles, one done.
    busy_cycles = 0; done_cnt = 0;
    cmd_fill = 1; cycle(); idle_inputs();
    repeat (105) cycle();
    check("fill_busy_cycles", 32'(busy_cycles), 100);
    check("fill_done_pulses", 32'(done_cnt), 1);
    check("fill_count", 32'(ent_num), 100);
    read_expect("fill_e0", 8'd0, rec(4, 0, 0));
    read_expect("fill_e37", 8'd37, rec(4, 144, 336));
    read_expect("fill_e99", 8'd99, rec(4, 432, 432));
    read_expect("fill_e100", 8'd100, 21'd0);

    // Clear, append two, overwrite one.
    cmd_clear = 1; cycle(); idle_inputs();
    do_write(8'd0, rec(1, 10, 20));
    do_write(8'd1, rec(2, 350, 100));
    check("append_count", 32'(ent_num), 2);
    read_expect("rd_e1", 8'd1, rec(2, 350, 100));
    do_write(8'd0, rec(3, 5, 5));
    check("overwrite_count", 32'(ent_num), 2);
    read_expect("rd_e0", 8'd0, rec(3, 5, 5));

    // Gap write is rejected.
    do_write(8'd5, rec(1, 1, 1));
    check("gap_err", 32'(wr_err), 1);
    check("gap_count", 32'(ent_num), 2);

    // Clear on the 20th fill cycle aborts without done.
    done_cnt = 0;
    cmd_fill = 1; cycle(); idle_inputs();
    repeat (19) cycle();
    cmd_clear = 1; cycle(); idle_inputs();
    check("abort_count", 32'(ent_num), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (5) cycle();
    check("abort_no_done", 32'(done_cnt), 0);
    do_write(8'd0, rec(5, 7, 9));
    check("post_abort_write", 32'(ent_num), 1);

    // Command priority.
    cmd_clear = 1; cmd_fill = 1; wr_en = 1; wr_addr = 8'd1; wr_data = rec(6, 6, 6);
    cycle(); idle_inputs();
    check("prio_clear_busy", 32'(busy), 0);
    check("prio_clear_count", 32'(ent_num), 0);
    cmd_fill = 1; wr_en = 1; wr_addr = 8'd0; wr_data = rec(6, 6, 6);
    cycle(); idle_inputs();
    check("prio_fill_busy", 32'(busy), 1);
    check("prio_fill_noerr", 32'(wr_err), 0);
    repeat (101) cycle();

    // Read-first on a same-address read/write.
    rd_addr = 8'd5;
    do_write(8'd5, rec(7, 300, 200));
    check("read_first", 32'(rd_data), 32'(rec(4, 0, 240)));
    read_expect("after_write", 8'd5, rec(7, 300, 200));

    // 12x12 grid clipped to a full table, then a write past the end.
    d12_fill = 1; @(negedge clk); d12_fill = 0;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (d12_done) seen = 1;
    end
    check("d12_done_seen", 32'(seen), 1);
    check("d12_count", 32'(d12_cnt), 128);
    d12_rd_addr = 8'd11; @(negedge clk);
    check("d12_e11_wrap", 32'(d12_rd_data), 32'(rec(4, 0, 16)));
    d12_rd_addr = 8'd127; @(negedge clk);
    check("d12_e127", 32'(d12_rd_data), 32'(rec(4, 480, 336)));
    d12_wr_en = 1; d12_wr_addr = 8'd128; d12_wr_data = rec(1, 1, 1);
    @(negedge clk); d12_wr_en = 0;
    check("d12_full_err", 32'(d12_err), 1);
    check("d12_full_count", 32'(d12_cnt), 128);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 99);
      cmd_clear = (r < 4);
      cmd_fill  = (r >= 4 && r < 7);
      wr_en     = ($urandom_range(0, 99) < 60);
      wr_addr   = 8'($urandom_range(0, m_cnt + 2));
      wr_data   = 21'($urandom);
      rd_addr   = 8'($urandom_range(0, m_cnt + 3));
      cycle();
    end
    idle_inputs();

    // Asynchronous reset in the middle of a fill.
    cmd_clear = 1; cycle(); idle_inputs();
    cmd_fill = 1; cycle(); idle_inputs();
    repeat (10) cycle();
    #2 rst_n = 0;
    #1;
    check("arst_data", 32'(rd_data), 0);
    check("arst_count", 32'(ent_num), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    m_cnt = 0; m_busy = 0;
    @(negedge clk);
    rst_n = 1;
    read_expect("arst_rd0", 8'd0, 21'd0);
    check("arst_count_after", 32'(ent_num), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
